fft_sequencer: RTL and testbench
================================

FFT_SEQUENCER -- requirements
Module: fft_sequencer

Interface
REQ-001 SHALL have parameter FCLK, default 50_000_000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter FS, default 10_000, meaning the sample rate in Hz; DIV = FCLK/FS, with DIV >= 4 checked at elaboration.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port chan_en, input, 8 bits: per-channel enable mask for ADC channels 0..7.
REQ-006 SHALL have ports adc_req (output, 1 bit, one-cycle conversion request) and adc_ch (output, 3 bits, channel for that request).
REQ-007 SHALL have ports adc_valid (input, 1 bit, conversion done) and adc_data (input, 12 bits, conversion result).
REQ-008 SHALL have ports buf_we (output, 1), buf_addr (output, 4) and buf_wdata (output, 12): the write port into the 16-point sample buffer.
REQ-009 SHALL have ports fft_start (output, 1, one-cycle pulse) and fft_done (input, 1, one-cycle pulse from the FFT engine).
REQ-010 SHALL have output frame_ch, 3 bits: the channel of the most recently started frame.
REQ-011 SHALL have output frame_cnt, 16 bits: count of completed frames, wrapping.
REQ-012 SHALL have output overrun (1 bit, sticky) and input ovr_clr (1 bit, clears overrun).

Function
REQ-013 Sample tick SHALL be a divider counting 0..DIV-1; tick is high for one cycle when count = DIV-1; the first tick occurs DIV cycles after reset release.
REQ-014 FSM states SHALL be IDLE, COLLECT, CONVERT, START, WAIT_FFT.
REQ-015 IDLE: if chan_en = 0, SHALL stay in IDLE. Otherwise SHALL load cur_ch with the first enabled channel at or after ptr (wrapping 7 to 0), clear idx to 0, and go to COLLECT.
REQ-016 COLLECT: on tick, SHALL pulse adc_req for one cycle with adc_ch = cur_ch and go to CONVERT.
REQ-017 CONVERT: on adc_valid, SHALL assert buf_we for one cycle with buf_addr = idx and buf_wdata = adc_data. If idx = 15, go to START; otherwise increment idx and go to COLLECT.
REQ-018 A tick arriving in CONVERT (including in the same cycle as adc_valid) SHALL be dropped and set overrun; the adc_valid in that cycle is still accepted.
REQ-019 START: SHALL pulse fft_start for one cycle, load frame_ch = cur_ch, and go to WAIT_FFT.
REQ-020 WAIT_FFT: ticks SHALL be ignored without setting overrun. On fft_done, SHALL increment frame_cnt (0xFFFF wraps to 0), set ptr = cur_ch+1 mod 8, and go to IDLE.
REQ-021 adc_valid outside CONVERT and fft_done outside WAIT_FFT SHALL be ignored.
REQ-022 chan_en changes mid-frame SHALL NOT affect the current frame; they take effect at the next IDLE evaluation.
REQ-023 If ovr_clr and an overrun set occur in the same cycle, set SHALL win.
REQ-024 Latency: the IDLE-to-COLLECT transition SHALL take 1 cycle; buf_we SHALL follow adc_valid by 1 cycle (registered outputs).

Reset
REQ-025 On reset_n low, SHALL asynchronously force: state = IDLE, divider = 0, ptr = 0, idx = 0, and cur_ch, frame_ch, frame_cnt, overrun, adc_req, adc_ch, buf_we, buf_addr, buf_wdata and fft_start all = 0.
REQ-026 Reset mid-frame SHALL abandon the frame; no fft_start SHALL be issued for the partial frame.

Structure
REQ-027 Package fft_seq_pkg SHALL hold the state enum and the constants NPTS = 16, ADC_W = 12, CH_W = 3 and CNT_W = 16.
REQ-028 The divider SHALL be a separate sub-module, sample_tick_gen (parameters FCLK and FS; ports clk, reset_n, tick).

Verification (FCLK = 1000, FS = 100, DIV = 10)
REQ-029 Reset release with chan_en = 0x01 and the ADC model answering 2 cycles after adc_req: first adc_req at cycle 10, then every 10 cycles; 16 buf_we with addr 0..15; fft_start after the 16th write; frame_ch = 0.
REQ-030 chan_en = 0x05 with fft_done returned 5 cycles after each fft_start: frames alternate on channels 0, 2, 0, 2; frame_cnt = 4 after four fft_done pulses.
REQ-031 ADC model holds adc_valid off for 12 cycles: overrun = 1 and the dropped tick produces no adc_req; ovr_clr pulse then gives overrun = 0; ovr_clr coincident with a new overrun leaves overrun = 1.
REQ-032 chan_en changed from 0x01 to 0x80 at sample 7: the current frame completes on channel 0; the next frame uses channel 7.
REQ-033 reset_n pulsed low at sample 9: all outputs are 0 immediately; no fft_start; the first adc_req comes 10 cycles after reset release, with buf_addr restarting at 0.
REQ-034 frame_cnt preloaded via force to 0xFFFF: the next fft_done gives frame_cnt = 0x0000.

Source files
------------

// File: rtl/fft_seq_pkg.sv
// Shared constants, FSM state encoding and channel-selection helper for the
// FFT sample sequencer.
package fft_seq_pkg;

    localparam int NPTS  = 16;
    localparam int ADC_W = 12;
    localparam int CH_W  = 3;
    localparam int CNT_W = 16;
    localparam int IDX_W = $clog2(NPTS);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_COLLECT  = 3'd1;
    localparam logic [2:0] ST_CONVERT  = 3'd2;
    localparam logic [2:0] ST_START    = 3'd3;
    localparam logic [2:0] ST_WAIT_FFT = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        COLLECT  = ST_COLLECT,
        CONVERT  = ST_CONVERT,
        START    = ST_START,
        WAIT_FFT = ST_WAIT_FFT
    } state_e;

    // Round-robin pick: first set bit of mask at or after start, wrapping 7->0.
    // Scanning the offsets downward lets the smallest offset win.
    function automatic logic [CH_W-1:0] first_enabled(input logic [7:0] mask,
                                                      input logic [CH_W-1:0] start);
        logic [CH_W-1:0] ch;
        first_enabled = start;
        for (int i = 7; i >= 0; i--) begin
            ch = start + CH_W'(i);
            if (mask[ch]) first_enabled = ch;
        end
    endfunction

endpackage

// File: rtl/fft_sequencer_tick.sv
// Sample-rate divider: counts 0..DIV-1 and flags the last count as the tick.
module sample_tick_gen #(
    parameter int FCLK = 50_000_000,
    parameter int FS   = 10_000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int DIV = FCLK / FS;
    localparam int CW  = $clog2(DIV);

    generate
        if (DIV < 4) begin : g_div_check
            $error("sample_tick_gen: FCLK/FS must be at least 4");
        end
    endgenerate

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                    count <= '0;
        else if (count == CW'(DIV - 1))  count <= '0;
        else                             count <= count + CW'(1);
    end

    assign tick = (count == CW'(DIV - 1));

endmodule

// File: rtl/fft_sequencer.sv
// Collects 16 ADC samples per frame from round-robin enabled channels into the
// sample buffer, then hands the frame to the FFT engine.
module fft_sequencer
    import fft_seq_pkg::*;
#(
    parameter int FCLK = 50_000_000,
    parameter int FS   = 10_000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        chan_en,
    output logic              adc_req,
    output logic [CH_W-1:0]   adc_ch,
    input  logic              adc_valid,
    input  logic [ADC_W-1:0]  adc_data,
    output logic              buf_we,
    output logic [IDX_W-1:0]  buf_addr,
    output logic [ADC_W-1:0]  buf_wdata,
    output logic              fft_start,
    input  logic              fft_done,
    output logic [CH_W-1:0]   frame_ch,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              overrun,
    input  logic              ovr_clr
);

    logic             tick;
    state_e           state;
    logic [CH_W-1:0]  cur_ch;
    logic [CH_W-1:0]  ptr;
    logic [IDX_W-1:0] idx;

    sample_tick_gen #(.FCLK(FCLK), .FS(FS)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cur_ch    <= '0;
            ptr       <= '0;
            idx       <= '0;
            adc_req   <= 1'b0;
            adc_ch    <= '0;
            buf_we    <= 1'b0;
            buf_addr  <= '0;
            buf_wdata <= '0;
            fft_start <= 1'b0;
            frame_ch  <= '0;
            frame_cnt <= '0;
            overrun   <= 1'b0;
        end else begin
            adc_req   <= 1'b0;
            buf_we    <= 1'b0;
            fft_start <= 1'b0;
            // Clear first so a same-cycle overrun set below takes priority.
            if (ovr_clr) overrun <= 1'b0;

            case (state)
                IDLE: begin
                    if (chan_en != 8'h00) begin
                        cur_ch <= first_enabled(chan_en, ptr);
                        idx    <= '0;
                        state  <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (tick) begin
                        adc_req <= 1'b1;
                        adc_ch  <= cur_ch;
                        state   <= CONVERT;
                    end
                end
                CONVERT: begin
                    // A tick here means the ADC is too slow; that sample is lost.
                    if (tick) overrun <= 1'b1;
                    if (adc_valid) begin
                        buf_we    <= 1'b1;
                        buf_addr  <= idx;
                        buf_wdata <= adc_data;
                        if (idx == IDX_W'(NPTS - 1)) begin
                            state <= START;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= COLLECT;
                        end
                    end
                end
                START: begin
                    fft_start <= 1'b1;
                    frame_ch  <= cur_ch;
                    state     <= WAIT_FFT;
                end
                WAIT_FFT: begin
                    if (fft_done) begin
                        frame_cnt <= frame_cnt + CNT_W'(1);
                        ptr       <= cur_ch + CH_W'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_sequencer.sv
// Directed bench for fft_sequencer with FCLK=1000, FS=100 (one tick per 10 clocks).
module tb_fft_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [7:0]  chan_en = 8'h00;
    logic        adc_req;
    logic [2:0]  adc_ch;
    logic        adc_valid = 1'b0;
    logic [11:0] adc_data = 12'h000;
    logic        buf_we;
    logic [3:0]  buf_addr;
    logic [11:0] buf_wdata;
    logic        fft_start;
    logic        fft_done = 1'b0;
    logic [2:0]  frame_ch;
    logic [15:0] frame_cnt;
    logic        overrun;
    logic        ovr_clr = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rel = 0;
    int adc_lat = 2;
    bit fft_auto = 1'b0;
    logic [11:0] mdl_d;
    logic [41:0] outs;

    int req_q[$];
    int reqch_q[$];
    int we_addr_q[$];
    int we_data_q[$];
    int fs_q[$];
    int fch_q[$];

    fft_sequencer #(.FCLK(1000), .FS(100)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .chan_en   (chan_en),
        .adc_req   (adc_req),
        .adc_ch    (adc_ch),
        .adc_valid (adc_valid),
        .adc_data  (adc_data),
        .buf_we    (buf_we),
        .buf_addr  (buf_addr),
        .buf_wdata (buf_wdata),
        .fft_start (fft_start),
        .fft_done  (fft_done),
        .frame_ch  (frame_ch),
        .frame_cnt (frame_cnt),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: answers adc_lat edges after the request; data = ch*256 + sample number.
    initial forever begin
        @(posedge clk); #1;
        if (adc_req) begin
            mdl_d = 12'(int'(adc_ch) * 256 + (cyc - rel) / 10);
            repeat (adc_lat) @(posedge clk);
            #1 adc_valid = 1'b1; adc_data = mdl_d;
            @(posedge clk); #1 adc_valid = 1'b0;
        end
    end

    // FFT model: fft_done pulse 5 edges after fft_start when enabled.
    initial forever begin
        @(posedge clk); #1;
        if (fft_start && fft_auto) begin
            repeat (5) @(posedge clk);
            #1 fft_done = 1'b1;
            @(posedge clk); #1 fft_done = 1'b0;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (adc_req)   begin req_q.push_back(cyc); reqch_q.push_back(int'(adc_ch)); end
        if (buf_we)    begin we_addr_q.push_back(int'(buf_addr)); we_data_q.push_back(int'(buf_wdata)); end
        if (fft_start) begin fs_q.push_back(cyc); fch_q.push_back(int'(frame_ch)); end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic clear_q();
        req_q.delete(); reqch_q.delete(); we_addr_q.delete();
        we_data_q.delete(); fs_q.delete(); fch_q.delete();
    endtask

    task automatic do_reset(input logic [7:0] en, input int alat, input bit fauto);
        reset_n = 1'b0; ovr_clr = 1'b0; chan_en = en; adc_lat = alat; fft_auto = fauto;
        repeat (3) step();
        clear_q();
        reset_n = 1'b1;
        rel = cyc;
    endtask

    task automatic test_reset();
        #3 reset_n = 1'b0;
        step(); step();
        outs = {adc_req, adc_ch, buf_we, buf_addr, buf_wdata, fft_start, frame_ch, frame_cnt, overrun};
        tests++; if (outs !== 42'h0) begin fails++; $display("FAIL reset_outputs: got %h expected 0", outs); end
        do_reset(8'h00, 2, 1'b0);
        wait_to(rel + 35);
        tests++; if (req_q.size() !== 0) begin fails++; $display("FAIL idle_no_chan: got %0d reqs expected 0", req_q.size()); end
        chan_en = 8'h01;
        wait_to(rel + 45);
        tests++; if (req_q[0] !== rel + 40) begin fails++; $display("FAIL late_enable_req: got %0d expected %0d", req_q[0] - rel, 40); end
    endtask

    task automatic test_single_frame();
        do_reset(8'h01, 2, 1'b0);
        wait_to(rel + 200);
        tests++; if (req_q.size() !== 16) begin fails++; $display("FAIL req_count: got %0d expected 16", req_q.size()); end
        tests++; if (req_q[0] !== rel + 10) begin fails++; $display("FAIL first_req: got %0d expected 10", req_q[0] - rel); end
        tests++; if (req_q[1] !== rel + 20) begin fails++; $display("FAIL second_req: got %0d expected 20", req_q[1] - rel); end
        tests++; if (req_q[15] !== rel + 160) begin fails++; $display("FAIL last_req: got %0d expected 160", req_q[15] - rel); end
        tests++; if (we_addr_q.size() !== 16) begin fails++; $display("FAIL we_count: got %0d expected 16", we_addr_q.size()); end
        for (int i = 0; i < 16; i++) begin
            tests++; if (we_addr_q[i] !== i) begin fails++; $display("FAIL buf_addr[%0d]: got %0d expected %0d", i, we_addr_q[i], i); end
        end
        tests++; if (we_data_q[0] !== 1) begin fails++; $display("FAIL wdata_first: got %0d expected 1", we_data_q[0]); end
        tests++; if (we_data_q[15] !== 16) begin fails++; $display("FAIL wdata_last: got %0d expected 16", we_data_q[15]); end
        tests++; if (fs_q.size() !== 1) begin fails++; $display("FAIL fft_start_count: got %0d expected 1", fs_q.size()); end
        tests++; if (fs_q[0] !== rel + 164) begin fails++; $display("FAIL fft_start_cycle: got %0d expected 164", fs_q[0] - rel); end
        tests++; if (fch_q[0] !== 0) begin fails++; $display("FAIL frame_ch: got %0d expected 0", fch_q[0]); end
    endtask

    task automatic test_back_to_back();
        int exp_ch[4] = '{0, 2, 0, 2};
        do_reset(8'h05, 2, 1'b1);
        wait_to(rel + 700);
        tests++; if (fch_q.size() !== 4) begin fails++; $display("FAIL frames_started: got %0d expected 4", fch_q.size()); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (fch_q[i] !== exp_ch[i]) begin fails++; $display("FAIL frame_ch[%0d]: got %0d expected %0d", i, fch_q[i], exp_ch[i]); end
        end
        tests++; if (frame_cnt !== 16'd4) begin fails++; $display("FAIL frame_cnt4: got %0d expected 4", frame_cnt); end
        tests++; if (fs_q[1] !== rel + 334) begin fails++; $display("FAIL second_start: got %0d expected 334", fs_q[1] - rel); end
        tests++; if (reqch_q[16] !== 2) begin fails++; $display("FAIL frame2_adc_ch: got %0d expected 2", reqch_q[16]); end
    endtask

    task automatic test_overrun();
        do_reset(8'h01, 12, 1'b0);
        wait_to(rel + 19);
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_before: got %b expected 0", overrun); end
        wait_to(rel + 25);
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_set: got %b expected 1", overrun); end
        tests++; if (req_q.size() !== 1) begin fails++; $display("FAIL dropped_tick_req: got %0d reqs expected 1", req_q.size()); end
        ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
        wait_to(rel + 39);
        ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_set_wins: got %b expected 1", overrun); end
        wait_to(rel + 45);
        tests++; if (req_q[1] !== rel + 30) begin fails++; $display("FAIL req_after_drop: got %0d expected 30", req_q[1] - rel); end
        tests++; if (we_addr_q[1] !== 1) begin fails++; $display("FAIL addr_after_drop: got %0d expected 1", we_addr_q[1]); end
    endtask

    task automatic test_chan_change();
        do_reset(8'h01, 2, 1'b1);
        wait_to(rel + 75);
        chan_en = 8'h80;
        wait_to(rel + 340);
        tests++; if (reqch_q[15] !== 0) begin fails++; $display("FAIL chg_last_ch: got %0d expected 0", reqch_q[15]); end
        tests++; if (fch_q[0] !== 0) begin fails++; $display("FAIL chg_frame0: got %0d expected 0", fch_q[0]); end
        tests++; if (reqch_q[16] !== 7) begin fails++; $display("FAIL chg_next_ch: got %0d expected 7", reqch_q[16]); end
        tests++; if (req_q[16] !== rel + 180) begin fails++; $display("FAIL chg_next_req: got %0d expected 180", req_q[16] - rel); end
        tests++; if (fch_q[1] !== 7) begin fails++; $display("FAIL chg_frame1: got %0d expected 7", fch_q[1]); end
        tests++; if (fs_q[1] !== rel + 334) begin fails++; $display("FAIL chg_start1: got %0d expected 334", fs_q[1] - rel); end
    endtask

    task automatic test_midframe_reset();
        do_reset(8'h04, 2, 1'b1);
        wait_to(rel + 93);
        tests++; if (buf_addr !== 4'd8) begin fails++; $display("FAIL pre_reset_addr: got %0d expected 8", buf_addr); end
        reset_n = 1'b0;
        #1;
        outs = {adc_req, adc_ch, buf_we, buf_addr, buf_wdata, fft_start, frame_ch, frame_cnt, overrun};
        tests++; if (outs !== 42'h0) begin fails++; $display("FAIL async_reset_outputs: got %h expected 0", outs); end
        repeat (3) step();
        clear_q();
        reset_n = 1'b1;
        rel = cyc;
        wait_to(rel + 30);
        tests++; if (req_q[0] !== rel + 10) begin fails++; $display("FAIL rst_first_req: got %0d expected 10", req_q[0] - rel); end
        tests++; if (we_addr_q[0] !== 0) begin fails++; $display("FAIL rst_addr: got %0d expected 0", we_addr_q[0]); end
        tests++; if (we_data_q[0] !== 12'h201) begin fails++; $display("FAIL rst_wdata: got %h expected 201", we_data_q[0]); end
        tests++; if (fs_q.size() !== 0) begin fails++; $display("FAIL rst_no_start: got %0d expected 0", fs_q.size()); end
    endtask

    task automatic test_cnt_wrap();
        do_reset(8'h01, 2, 1'b1);
        wait_to(rel + 100);
        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        wait_to(rel + 169);
        tests++; if (frame_cnt !== 16'hFFFF) begin fails++; $display("FAIL cnt_preload: got %h expected ffff", frame_cnt); end
        wait_to(rel + 171);
        tests++; if (frame_cnt !== 16'h0000) begin fails++; $display("FAIL cnt_wrap: got %h expected 0000", frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overrun();
        test_chan_change();
        test_midframe_reset();
        test_cnt_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
